// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: drives the 8-LED bar with a pattern engine.
// The engine has a programmable-rate tick, a five-mode pattern FSM,
// a debounced mode button and a run/pause gate.
// All outputs are registered.
module led_seq_ctrl #(
    parameter int PRESCALE = 524288,
    parameter int DEB_CYC  = 250000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iBTN_MODE,
    input  logic [1:0] iSPEED,
    input  logic       iRUN,
    output logic [7:0] oLED,
    output logic [2:0] oMODE,
    output logic       oTICK
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int DEB_W = $clog2(DEB_CYC);

    typedef enum logic [2:0] {
        MODE_SHR    = 3'd0,
        MODE_SHL    = 3'd1,
        MODE_BOUNCE = 3'd2,
        MODE_BLINK  = 3'd3,
        MODE_OFF    = 3'd4
    } mode_t;

    // Button path
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             rise_q, rise_d;

    // Tick generator
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] period_m1;
    logic             tick_now;
    logic             tick_q, tick_d;

    // Pattern engine (dir: 0 = moving right, 1 = moving left)
    mode_t            mode_q, mode_d;
    logic [7:0]       led_q, led_d;
    logic             dir_q, dir_d;

    // Two-flop synchronizer feeding the debouncer.
    // The debounced level flips after DEB_CYC consecutive disagreeing samples.
    always_comb begin
        sync1_d   = iBTN_MODE;
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        rise_d    = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYC - 1)) begin
                deb_d     = ~deb_q;
                deb_cnt_d = '0;
                // Only a press (0->1) requests a mode advance.
                rise_d    = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Button path registers.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            rise_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            rise_q    <= rise_d;
        end
    end

    // Prescaler: '>=' makes a mid-count speed-up tick at once instead of wrapping.
    always_comb begin
        period_m1 = CNT_W'((PRESCALE >> iSPEED) - 1);
        tick_now  = iRUN && (presc_q >= period_m1);
        tick_d    = tick_now;
        presc_d   = presc_q;
        if (iRUN) begin
            presc_d = tick_now ? '0 : presc_q + CNT_W'(1);
        end
        // A mode advance restarts the tick period from zero.
        if (rise_q) begin
            presc_d = '0;
        end
    end

    // Prescaler and tick pulse registers.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // Mode FSM and pattern step.
    // A mode advance outranks a coincident tick: the pattern loads unshifted.
    always_comb begin
        mode_d = mode_q;
        led_d  = led_q;
        dir_d  = dir_q;
        case (mode_q)
            MODE_SHR, MODE_SHL, MODE_BOUNCE, MODE_BLINK, MODE_OFF: begin
                if (rise_q) begin
                    case (mode_q)
                        MODE_SHR:    begin mode_d = MODE_SHL;    led_d = 8'h01; end
                        MODE_SHL:    begin mode_d = MODE_BOUNCE; led_d = 8'h80; dir_d = 1'b0; end
                        MODE_BOUNCE: begin mode_d = MODE_BLINK;  led_d = 8'hFF; end
                        MODE_BLINK:  begin mode_d = MODE_OFF;    led_d = 8'h00; end
                        default:     begin mode_d = MODE_SHR;    led_d = 8'h80; end
                    endcase
                end else if (tick_now) begin
                    case (mode_q)
                        MODE_SHR: led_d = {led_q[0], led_q[7:1]};
                        MODE_SHL: led_d = {led_q[6:0], led_q[7]};
                        MODE_BOUNCE: begin
                            if (!dir_q) begin
                                led_d = {led_q[0], led_q[7:1]};
                                if (led_d == 8'h01) dir_d = 1'b1;
                            end else begin
                                led_d = {led_q[6:0], led_q[7]};
                                if (led_d == 8'h80) dir_d = 1'b0;
                            end
                        end
                        MODE_BLINK: led_d = ~led_q;
                        default:    led_d = 8'h00;
                    endcase
                end
            end
            default: begin
                // Unreachable codes recover to SHR with its initial pattern.
                mode_d = MODE_SHR;
                led_d  = 8'h80;
                dir_d  = 1'b0;
            end
        endcase
    end

    // Mode, pattern and bounce-direction registers.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            mode_q <= MODE_SHR;
            led_q  <= 8'h80;
            dir_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
        end
    end

    assign oLED  = led_q;
    assign oMODE = mode_q;
    assign oTICK = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: randomized bench for led_seq_ctrl with PRESCALE=8, DEB_CYC=4.
// The reference model tracks the pattern as a position or table index.
// It tracks the button as a sample delay line plus a stability window.
module tb_led_seq_ctrl;

    localparam int PRE = 8;
    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [1:0] speed;
    logic       run;
    logic [7:0] led;
    logic [2:0] mode;
    logic       tick;

    led_seq_ctrl #(.PRESCALE(PRE), .DEB_CYC(DEB)) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iBTN_MODE (btn),
        .iSPEED    (speed),
        .iRUN      (run),
        .oLED      (led),
        .oMODE     (mode),
        .oTICK     (tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int   m_cnt, m_mode, m_pos, m_bidx;
    bit   m_blink, m_tick, m_deb, m_pend;
    bit   dly[$];
    bit   win[$];
    logic [7:0] bounce_tab [14] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                                    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_led();
        case (m_mode)
            0, 1:    return 8'(1 << m_pos);
            2:       return bounce_tab[m_bidx];
            3:       return m_blink ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step(input bit r_n, input bit b, input int spd, input bit rn);
        bit adv, seen, flip, tk;
        int p;
        if (!r_n) begin
            m_cnt = 0; m_mode = 0; m_pos = 7; m_bidx = 0; m_blink = 1'b1;
            m_tick = 1'b0; m_deb = 1'b0; m_pend = 1'b0;
            dly.delete(); dly.push_back(1'b0); dly.push_back(1'b0);
            win.delete();
            return;
        end
        adv  = m_pend;
        // Synchronized level seen at this edge is the raw sample from two edges ago.
        seen = dly.pop_front();
        dly.push_back(b);
        win.push_back(seen);
        if (win.size() > DEB) void'(win.pop_front());
        flip = (win.size() == DEB);
        foreach (win[i]) if (win[i] == m_deb) flip = 1'b0;
        if (flip) begin
            m_deb = !m_deb;
            win.delete();
        end
        m_pend = flip && m_deb;
        p  = PRE >> spd;
        tk = rn && (m_cnt >= p - 1);
        if (adv)     m_cnt = 0;
        else if (rn) m_cnt = tk ? 0 : m_cnt + 1;
        if (adv) begin
            m_mode = (m_mode + 1) % 5;
            case (m_mode)
                0: m_pos = 7;
                1: m_pos = 0;
                2: m_bidx = 0;
                3: m_blink = 1'b1;
                default: ;
            endcase
        end else if (tk) begin
            case (m_mode)
                0: m_pos = (m_pos + 7) % 8;
                1: m_pos = (m_pos + 1) % 8;
                2: m_bidx = (m_bidx + 1) % 14;
                3: m_blink = !m_blink;
                default: ;
            endcase
        end
        m_tick = tk;
    endtask

    // One clock: drive inputs, step model on the edge, compare 1 time unit later.
    task automatic cycle(input bit r_n, input bit b, input int spd, input bit rn);
        rst_n = r_n; btn = b; speed = 2'(spd); run = rn;
        @(posedge clk);
        model_step(r_n, b, spd, rn);
        #1;
        chk("led",  32'(led),  32'(exp_led()));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("tick", 32'(tick), 32'(m_tick));
    endtask

    initial begin
        int len, blen, spd;
        bit rn, do_rst;
        rst_n = 1'b0; btn = 1'b0; speed = 2'd0; run = 1'b0;

        // Reset, then free run at full period
        repeat (2) cycle(0, 0, 0, 0);
        $display("seg reset: led=%02h mode=%0d tick=%0b", led, mode, tick);
        repeat (80) cycle(1, 0, 0, 1);
        $display("seg freerun: led=%02h mode=%0d", led, mode);

        // Short glitch, then a real press into SHL, then pause
        repeat (3) cycle(1, 1, 0, 1);
        repeat (10) cycle(1, 0, 0, 1);
        repeat (6) cycle(1, 1, 0, 1);
        repeat (10) cycle(1, 0, 0, 1);
        repeat (20) cycle(1, 0, 0, 0);
        $display("seg press+pause: led=%02h mode=%0d", led, mode);

        // Randomized segments
        for (int s = 0; s < 150; s++) begin
            len    = $urandom_range(8, 60);
            blen   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
            spd    = $urandom_range(0, 3);
            rn     = ($urandom_range(0, 7) != 0);
            do_rst = ($urandom_range(0, 29) == 0);
            if (do_rst) cycle(0, 0, spd, rn);
            for (int c = 0; c < len; c++) begin
                // Occasional mid-segment speed change exercises the '>=' wrap.
                if (c == len / 2 && $urandom_range(0, 3) == 0) spd = $urandom_range(0, 3);
                cycle(1, (c < blen), spd, rn);
            end
            $display("seg %0d: rst=%0b btn_len=%0d speed=%0d run=%0b len=%0d mode=%0d led=%02h",
                     s, do_rst, blen, spd, rn, len, mode, led);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
